// File: rtl/sseg_page_scheduler.sv
// Seven-segment page scheduler: rotates page A / page B on a dwell timer and
// preempts both for a held message, driving the registered hex word and dp mask.
//
// state | meaning
// ------+----------------------------------------------------------
// S_A   | page A buffer on display, dwell counter running
// S_B   | page B buffer on display, dwell counter running
// S_MSG | message buffer on display, hold counter running
module sseg_page_scheduler #(
    parameter int DWELL_TICKS = 100_000_000,
    parameter int HOLD_TICKS  = 200_000_000,
    parameter int TICK_W      = 28
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    input  logic [15:0] i_a_data,
    input  logic [3:0]  i_a_dp,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [15:0] i_b_data,
    input  logic [3:0]  i_b_dp,
    output logic        o_b_ready,
    input  logic        i_msg_valid,
    input  logic [15:0] i_msg_data,
    input  logic [3:0]  i_msg_dp,
    output logic        o_msg_ready,
    input  logic        i_freeze,
    output logic [15:0] o_hex,
    output logic [3:0]  o_dp,
    output logic [1:0]  o_page,
    output logic        o_page_tick
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_MSG = 2'b10
    } state_t;

    localparam logic [TICK_W-1:0] DWELL_LAST = TICK_W'(DWELL_TICKS - 1);
    localparam logic [TICK_W-1:0] HOLD_LAST  = TICK_W'(HOLD_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);

    state_t            state;
    state_t            state_nxt;
    state_t            ret_page;
    logic [TICK_W-1:0] dwell_cnt;
    logic [TICK_W-1:0] dwell_nxt;
    logic [TICK_W-1:0] hold_cnt;
    logic [TICK_W-1:0] hold_nxt;

    logic [15:0] a_data_q;
    logic [3:0]  a_dp_q;
    logic [15:0] b_data_q;
    logic [3:0]  b_dp_q;
    logic [15:0] m_data_q;
    logic [3:0]  m_dp_q;

    logic [15:0] a_data_nxt;
    logic [3:0]  a_dp_nxt;
    logic [15:0] b_data_nxt;
    logic [3:0]  b_dp_nxt;
    logic [15:0] m_data_nxt;
    logic [3:0]  m_dp_nxt;
    logic [15:0] hex_nxt;
    logic [3:0]  dp_nxt;

    logic a_we;
    logic b_we;
    logic m_acc;

    assign a_we  = i_a_valid & o_a_ready;
    assign b_we  = i_b_valid & o_b_ready;
    assign m_acc = i_msg_valid & o_msg_ready & (state != S_MSG);

    assign a_data_nxt = a_we  ? i_a_data   : a_data_q;
    assign a_dp_nxt   = a_we  ? i_a_dp     : a_dp_q;
    assign b_data_nxt = b_we  ? i_b_data   : b_data_q;
    assign b_dp_nxt   = b_we  ? i_b_dp     : b_dp_q;
    assign m_data_nxt = m_acc ? i_msg_data : m_data_q;
    assign m_dp_nxt   = m_acc ? i_msg_dp   : m_dp_q;

    // A message accept outranks a dwell expiry on the same cycle.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            S_A, S_B: begin
                if (m_acc) begin
                    state_nxt = S_MSG;
                    hold_nxt  = '0;
                    dwell_nxt = '0;
                end else if (!i_freeze) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        state_nxt = (state == S_A) ? S_B : S_A;
                        dwell_nxt = '0;
                    end else begin
                        dwell_nxt = dwell_cnt + TICK_ONE;
                    end
                end
            end
            S_MSG: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ret_page;
                    dwell_nxt = '0;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + TICK_ONE;
                end
            end
            default: begin
                state_nxt = S_A;
                dwell_nxt = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Display mux looks at post-edge buffers so a same-cycle write shows at once.
    always_comb begin
        hex_nxt = a_data_nxt;
        dp_nxt  = a_dp_nxt;
        case (state_nxt)
            S_B: begin
                hex_nxt = b_data_nxt;
                dp_nxt  = b_dp_nxt;
            end
            S_MSG: begin
                hex_nxt = m_data_nxt;
                dp_nxt  = m_dp_nxt;
            end
            default: begin
                hex_nxt = a_data_nxt;
                dp_nxt  = a_dp_nxt;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_A;
            ret_page    <= S_A;
            dwell_cnt   <= '0;
            hold_cnt    <= '0;
            a_data_q    <= '0;
            a_dp_q      <= '0;
            b_data_q    <= '0;
            b_dp_q      <= '0;
            m_data_q    <= '0;
            m_dp_q      <= '0;
            o_a_ready   <= 1'b0;
            o_b_ready   <= 1'b0;
            o_msg_ready <= 1'b0;
            o_hex       <= '0;
            o_dp        <= '0;
            o_page      <= 2'b00;
            o_page_tick <= 1'b0;
        end else begin
            state       <= state_nxt;
            dwell_cnt   <= dwell_nxt;
            hold_cnt    <= hold_nxt;
            a_data_q    <= a_data_nxt;
            a_dp_q      <= a_dp_nxt;
            b_data_q    <= b_data_nxt;
            b_dp_q      <= b_dp_nxt;
            m_data_q    <= m_data_nxt;
            m_dp_q      <= m_dp_nxt;
            if (m_acc) begin
                ret_page <= state;
            end
            o_a_ready   <= 1'b1;
            o_b_ready   <= 1'b1;
            o_msg_ready <= (state_nxt != S_MSG);
            o_hex       <= hex_nxt;
            o_dp        <= dp_nxt;
            o_page      <= state_nxt;
            o_page_tick <= (state_nxt != state);
        end
    end

endmodule
